// File: rtl/id_ex_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_pkg
// Shared definitions for the ID/EX pipeline boundary:
//   - NOP_INSTR : canonical NOP (addi x0, x0, 0) presented when EX side is idle
//   - state_e   : occupancy state of the ID/EX boundary (EMPTY / FULL / SKID)
//   - rd_gate() : write-enable qualification helper (x0 is never written)
// -----------------------------------------------------------------------------
package id_ex_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_e;

  // Register write enable is meaningless for x0, so it is dropped at capture.
  function automatic logic rd_gate(input logic reg_enable, input logic rd_is_zero);
    return reg_enable & ~rd_is_zero;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// pipeline_reg_en
// Width-parametrised payload register with load enable and synchronous clear.
// Clear has priority over load; the clear value is a parameter so the main
// entry can clear to a NOP payload while the skid entry clears to zero.
// Ports:
//   clk   in   clock
//   clr   in   synchronous clear (loads CLR_VAL)
//   en    in   load enable (loads d)
//   d     in   W-bit next payload
//   q     out  W-bit held payload (registered)
// -----------------------------------------------------------------------------
module pipeline_reg_en #(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Next payload: clear beats load, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = CLR_VAL;
    end else if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
// ID -> EX pipeline register with a one-entry skid buffer so that id_ready is
// a flop output rather than a combinational function of ex_ready.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   id_valid / id_ready              ID-side handshake (id_ready registered)
//   id_instr, id_addr, op1, op2      XLEN-bit decoded fields from ID
//   rd_addr, reg_enable              destination register and write enable
//   flush                            drop every held entry (redirect)
//   ex_valid / ex_ready              EX-side handshake (ex_valid registered)
//   ex_instr, ex_addr, ex_op1, ex_op2, ex_rd_addr, ex_reg_enable
//                                    registered copies of the ID fields;
//                                    NOP / zero whenever ex_valid is low
// -----------------------------------------------------------------------------
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_instr,
  input  logic [XLEN-1:0] id_addr,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [RD_W-1:0] rd_addr,
  input  logic            reg_enable,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_instr,
  output logic [XLEN-1:0] ex_addr,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [RD_W-1:0] ex_rd_addr,
  output logic            ex_reg_enable
);

  localparam int PW = 4*XLEN + RD_W + 1;
  localparam logic [XLEN-1:0] NOP_X    = XLEN'(NOP_INSTR);
  localparam logic [PW-1:0]   MAIN_CLR = {NOP_X, {(3*XLEN+RD_W+1){1'b0}}};
  localparam logic [PW-1:0]   SKID_CLR = {PW{1'b0}};

  state_e        state_q;
  state_e        state_d;
  logic          id_ready_q;
  logic          id_ready_d;
  logic          ex_valid_q;
  logic          ex_valid_d;

  logic          in_fire_s;
  logic          out_fire_s;
  logic          main_load_s;
  logic          main_clr_s;
  logic          main_from_skid_s;
  logic          skid_load_s;
  logic          skid_clr_s;

  logic [PW-1:0] payload_in_s;
  logic [PW-1:0] main_in_s;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  assign in_fire_s  = id_valid & id_ready_q;
  assign out_fire_s = ex_valid_q & ex_ready;

  // Write enable is qualified here so the held copy already reflects x0.
  assign payload_in_s = {id_instr, id_addr, op1, op2, rd_addr,
                         rd_gate(reg_enable, (rd_addr == {RD_W{1'b0}}))};

  // State and handshake flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      id_ready_q <= 1'b1;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_ready_q <= id_ready_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  // Next-state: occupancy transitions, flush overrides all of them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_s) state_d = ST_FULL;
        else           state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (in_fire_s && out_fire_s)  state_d = ST_FULL;
        else if (in_fire_s)           state_d = ST_SKID;
        else if (out_fire_s)          state_d = ST_EMPTY;
        else                          state_d = ST_FULL;
      end
      ST_SKID: begin
        if (out_fire_s) state_d = ST_FULL;
        else            state_d = ST_SKID;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_d;
    end
  end

  // Outputs of the FSM: next handshake values and storage controls.
  always_comb begin
    id_ready_d       = (state_d != ST_SKID);
    ex_valid_d       = (state_d != ST_EMPTY);
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        main_load_s = in_fire_s;
      end
      ST_FULL: begin
        main_load_s = in_fire_s & out_fire_s;
        skid_load_s = in_fire_s & ~out_fire_s;
      end
      ST_SKID: begin
        main_load_s      = out_fire_s;
        main_from_skid_s = 1'b1;
      end
      default: begin
        main_load_s = 1'b0;
      end
    endcase
    // An empty EX side must present the NOP payload, so clear main whenever
    // the boundary is about to become empty (drain or flush).
    main_clr_s = reset | (state_d == ST_EMPTY);
    skid_clr_s = reset | flush;
  end

  assign main_in_s = main_from_skid_s ? skid_q : payload_in_s;

  pipeline_reg_en #(
    .W       (PW),
    .CLR_VAL (MAIN_CLR)
  ) u_main_reg (
    .clk (clk),
    .clr (main_clr_s),
    .en  (main_load_s),
    .d   (main_in_s),
    .q   (main_q)
  );

  pipeline_reg_en #(
    .W       (PW),
    .CLR_VAL (SKID_CLR)
  ) u_skid_reg (
    .clk (clk),
    .clr (skid_clr_s),
    .en  (skid_load_s),
    .d   (payload_in_s),
    .q   (skid_q)
  );

  assign id_ready      = id_ready_q;
  assign ex_valid      = ex_valid_q;
  assign ex_instr      = main_q[PW-1        -: XLEN];
  assign ex_addr       = main_q[PW-1-XLEN   -: XLEN];
  assign ex_op1        = main_q[PW-1-2*XLEN -: XLEN];
  assign ex_op2        = main_q[PW-1-3*XLEN -: XLEN];
  assign ex_rd_addr    = main_q[RD_W:1];
  assign ex_reg_enable = main_q[0];

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the driver pushes the expected EX payload
// when an entry is accepted; the monitor compares on the falling edge.
module tb_id_ex_pipe;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int PW   = 4*XLEN + RD_W + 1;

  logic            clk;
  logic            reset;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_addr;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [RD_W-1:0] rd_addr;
  logic            reg_enable;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_instr;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [RD_W-1:0] ex_rd_addr;
  logic            ex_reg_enable;

  int errors;
  int checks;
  int pops;
  int p0;
  logic mon_en;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got;
  logic [PW-1:0] idle_pl;

  id_ex_pipe #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_addr       (id_addr),
    .op1           (op1),
    .op2           (op2),
    .rd_addr       (rd_addr),
    .reg_enable    (reg_enable),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_instr      (ex_instr),
    .ex_addr       (ex_addr),
    .ex_op1        (ex_op1),
    .ex_op2        (ex_op2),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_enable (ex_reg_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the model is updated after the monitor has run.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] rd,
                       input logic re, input logic fl, input logic rst, input logic exr);
    logic acc;
    logic [31:0] a;
    logic [31:0] o1;
    logic [31:0] o2;
    @(posedge clk);
    #1;
    a  = $urandom;
    o1 = $urandom;
    o2 = $urandom;
    id_valid = v; id_instr = ins; id_addr = a; op1 = o1; op2 = o2;
    rd_addr = rd; reg_enable = re; flush = fl; reset = rst; ex_ready = exr;
    acc = v && (exp_q.size() < 2);
    @(negedge clk);
    #1;
    if (rst || fl) exp_q.delete();
    else if (acc) exp_q.push_back({ins, a, o1, o2, rd, (re && (rd != 5'd0))});
  endtask

  task automatic idle(input int n, input logic exr);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, exr);
  endtask

  // Monitor: compare status and presented payload against the model queue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ex_valid", PW'(ex_valid), PW'(exp_q.size() != 0));
      check("id_ready", PW'(id_ready), PW'(exp_q.size() < 2));
      got = {ex_instr, ex_addr, ex_op1, ex_op2, ex_rd_addr, ex_reg_enable};
      if (ex_valid && exp_q.size() > 0) check("ex_payload", got, exp_q[0]);
      else if (!ex_valid) check("ex_idle", got, idle_pl);
      if (ex_valid && ex_ready && !reset && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
  end

  initial begin
    errors = 0; checks = 0; pops = 0; mon_en = 1'b0;
    idle_pl = {32'h0000_0013, {(3*XLEN+RD_W+1){1'b0}}};
    reset = 1'b1; id_valid = 1'b0; id_instr = 32'h0; id_addr = 32'h0;
    op1 = 32'h0; op2 = 32'h0; rd_addr = 5'd0; reg_enable = 1'b0;
    flush = 1'b0; ex_ready = 1'b0;

    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b1;
    idle(2, 1'b0);

    // Back-to-back stream
    p0 = pops;
    drive(1'b1, 32'h0010_0093, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h0020_0113, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h0030_0193, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("stream_pops", PW'(pops - p0), PW'(3));

    // Backpressure into skid, then release
    p0 = pops;
    drive(1'b1, 32'hAAAA_0001, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hBBBB_0002, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hCCCC_0003, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    check("backpressure_pops", PW'(pops - p0), PW'(2));

    // Flush while in skid with a new entry presented
    p0 = pops;
    drive(1'b1, 32'hDDDD_0004, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hEEEE_0005, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFF_0006, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    check("flush_pops", PW'(pops - p0), PW'(0));

    // Write enable suppressed for x0
    p0 = pops;
    drive(1'b1, 32'h1111_0007, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h2222_0008, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("rd_zero_pops", PW'(pops - p0), PW'(2));

    // Reset while in skid with EX stalled
    p0 = pops;
    drive(1'b1, 32'h3333_0009, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h4444_000A, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    check("reset_pops", PW'(pops - p0), PW'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom,
            (($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom)),
            1'($urandom), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6));
    end
    idle(4, 1'b1);
    check("drained", PW'(exp_q.size()), PW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
